// File: rtl/out_tx.sv
`default_nettype none
// ============================================================================
// Module      : out_tx
// Description : OUT-port UART transmitter. Buffers 16-bit words in a small FIFO
//               and sends each one as two back-to-back 8N1 frames, high byte first.
// Revision    : 1.0 - initial release
// ============================================================================
module out_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_outr,
    input  logic [15:0] ra,
    output logic        txd,
    output logic        busy,
    output logic        full,
    output logic        overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CLK_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(FIFO_DEPTH);
    localparam logic [CLK_W-1:0] c_last_clk = CLK_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic [15:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [1:0]       r_state;
    logic             r_byte_sel;
    logic [15:0]      r_hold;
    logic [2:0]       r_bit_cnt;
    logic [CLK_W-1:0] r_clk_cnt;
    logic             r_txd;

    logic [1:0]       w_state_n;
    logic             w_byte_sel_n;
    logic [15:0]      w_hold_n;
    logic [2:0]       w_bit_cnt_n;
    logic [CLK_W-1:0] w_clk_cnt_n;
    logic [7:0]       w_byte_n;
    logic             w_txd_n;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_last;
    logic             w_not_empty;
    logic             w_is_full;

    assign w_last      = (r_clk_cnt == c_last_clk);
    assign w_not_empty = (r_count != '0);
    assign w_is_full   = (r_count == c_depth);
    // A pop on the same edge frees a slot, so a strobe into a full FIFO still lands.
    assign w_push      = ld_outr && (!w_is_full || w_pop);
    assign w_drop      = ld_outr && w_is_full && !w_pop;

    always_comb begin
        w_state_n    = r_state;
        w_byte_sel_n = r_byte_sel;
        w_hold_n     = r_hold;
        w_bit_cnt_n  = r_bit_cnt;
        w_clk_cnt_n  = r_clk_cnt;
        w_pop        = 1'b0;
        w_byte_n     = 8'h00;
        w_txd_n      = 1'b1;

        case (r_state)
            c_st_idle: begin
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_hold_n     = r_mem[r_rd_ptr];
                    w_byte_sel_n = 1'b0;
                    w_clk_cnt_n  = '0;
                    w_bit_cnt_n  = 3'd0;
                    w_state_n    = c_st_start;
                end
            end
            c_st_start: begin
                if (w_last) begin
                    w_clk_cnt_n = '0;
                    w_bit_cnt_n = 3'd0;
                    w_state_n   = c_st_data;
                end else begin
                    w_clk_cnt_n = r_clk_cnt + CLK_W'(1);
                end
            end
            c_st_data: begin
                if (w_last) begin
                    w_clk_cnt_n = '0;
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_cnt_n = 3'd0;
                        w_state_n   = c_st_stop;
                    end else begin
                        w_bit_cnt_n = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_clk_cnt_n = r_clk_cnt + CLK_W'(1);
                end
            end
            default: begin
                if (w_last) begin
                    w_clk_cnt_n = '0;
                    if (!r_byte_sel) begin
                        w_byte_sel_n = 1'b1;
                        w_state_n    = c_st_start;
                    end else if (w_not_empty) begin
                        w_pop        = 1'b1;
                        w_hold_n     = r_mem[r_rd_ptr];
                        w_byte_sel_n = 1'b0;
                        w_state_n    = c_st_start;
                    end else begin
                        w_state_n    = c_st_idle;
                    end
                end else begin
                    w_clk_cnt_n = r_clk_cnt + CLK_W'(1);
                end
            end
        endcase

        // Line level is computed from the next state so txd comes straight from a flop.
        w_byte_n = w_byte_sel_n ? w_hold_n[7:0] : w_hold_n[15:8];
        case (w_state_n)
            c_st_start: w_txd_n = 1'b0;
            c_st_data:  w_txd_n = w_byte_n[w_bit_cnt_n];
            default:    w_txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ra;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_state    <= c_st_idle;
            r_byte_sel <= 1'b0;
            r_hold     <= 16'h0000;
            r_bit_cnt  <= 3'd0;
            r_clk_cnt  <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_n;
            r_byte_sel <= w_byte_sel_n;
            r_hold     <= w_hold_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_clk_cnt  <= w_clk_cnt_n;
            r_txd      <= w_txd_n;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign txd      = r_txd;
    assign busy     = (r_state != c_st_idle) || w_not_empty;
    assign full     = w_is_full;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_out_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_tx
// Description : Self-checking bench for out_tx against a queue-based line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        ld_outr  = 1'b0;
    logic [15:0] ra       = 16'h0000;
    wire         txd;
    wire         busy;
    wire         full;
    wire         overflow;

    always #5 clk = ~clk;

    out_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ld_outr (ld_outr),
        .ra      (ra),
        .txd     (txd),
        .busy    (busy),
        .full    (full),
        .overflow(overflow)
    );

    int errors = 0;
    int checks = 0;

    // Model: words waiting, plus the per-cycle line levels still to be sent.
    logic [15:0] m_fifo[$];
    bit          m_line[$];
    bit          m_txd    = 1'b1;
    bit          m_active = 1'b0;
    bit          m_ovf    = 1'b0;

    bit          s_txd [200];
    bit          s_busy[200];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_fifo.delete();
        m_line.delete();
        m_txd    = 1'b1;
        m_active = 1'b0;
        m_ovf    = 1'b0;
    endfunction

    function automatic void m_step(input bit ld, input logic [15:0] d);
        logic [15:0] w;
        logic [7:0]  b;
        if (m_line.size() == 0 && m_fifo.size() > 0) begin
            w = m_fifo.pop_front();
            for (int f = 0; f < 2; f++) begin
                b = (f == 0) ? w[15:8] : w[7:0];
                for (int c = 0; c < CPB; c++) m_line.push_back(1'b0);
                for (int i = 0; i < 8; i++)
                    for (int c = 0; c < CPB; c++) m_line.push_back(b[i]);
                for (int c = 0; c < CPB; c++) m_line.push_back(1'b1);
            end
        end
        if (ld) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
            else m_ovf = 1'b1;
        end
        if (m_line.size() > 0) begin
            m_txd    = m_line.pop_front();
            m_active = 1'b1;
        end else begin
            m_txd    = 1'b1;
            m_active = 1'b0;
        end
    endfunction

    task automatic compare_outputs();
        check("txd",      {31'd0, txd},      {31'd0, m_txd});
        check("busy",     {31'd0, busy},     {31'd0, (m_active || m_fifo.size() > 0)});
        check("full",     {31'd0, full},     {31'd0, (m_fifo.size() == DEPTH)});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic cycle(input bit ld, input logic [15:0] d);
        ld_outr = ld;
        ra      = d;
        @(posedge clk);
        m_step(ld, d);
        #1;
        ld_outr = 1'b0;
        compare_outputs();
    endtask

    task automatic do_reset();
        ld_outr = 1'b0;
        rst     = 1'b0;
        #1;
        m_reset();
        check("rst_txd",      {31'd0, txd},      32'd1);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_full",     {31'd0, full},     32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit exp_a53c[20] = '{0, 1,0,1,0,0,1,0,1, 1, 0, 0,0,1,1,1,1,0,0, 1};
        bit found;
        int zeros, first_low, last_low, full_seen, lows;
        int p;

        #12;
        check("por_txd",      {31'd0, txd},      32'd1);
        check("por_busy",     {31'd0, busy},     32'd0);
        check("por_full",     {31'd0, full},     32'd0);
        check("por_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single word 0xA53C, checked bit by bit against the literal frame pattern.
        for (int k = 1; k < 100; k++) begin
            cycle(k == 1, 16'hA53C);
            s_txd[k]  = txd;
            s_busy[k] = busy;
        end
        check("a53c_first_low", {31'd0, s_txd[2]}, 32'd0);
        for (int j = 0; j < 20; j++)
            check("a53c_bit", {31'd0, s_txd[3 + 4 * j]}, {31'd0, exp_a53c[j]});
        check("a53c_busy_last", {31'd0, s_busy[81]}, 32'd1);
        check("a53c_busy_done", {31'd0, s_busy[82]}, 32'd0);

        // Six back-to-back strobes: one popped, four buffered, one dropped.
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1'b1, 16'h1000 * (k + 1) + 16'h0055);
        check("six_overflow", {31'd0, overflow}, 32'd1);
        for (int k = 0; k < 5 * 20 * CPB + 10; k++) cycle(1'b0, 16'h0000);
        check("six_drained", {31'd0, busy}, 32'd0);

        // Strobe into a full FIFO exactly on a pop edge.
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, 16'h0F00 + 16'(k));
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (m_line.size() == 0 && m_fifo.size() == DEPTH) begin
                cycle(1'b1, 16'hBEEF);
                found = 1'b1;
                check("popedge_full", {31'd0, full},     32'd1);
                check("popedge_ovf",  {31'd0, overflow}, 32'd0);
            end else begin
                cycle(1'b0, 16'h0000);
            end
        end
        check("popedge_found", {31'd0, found}, 32'd1);
        for (int k = 0; k < 5 * 20 * CPB; k++) cycle(1'b0, 16'h0000);

        // Reset during data bit 3 of the first frame with two words queued.
        do_reset();
        for (int k = 0; k < 19; k++) cycle(k < 3, 16'h5A00 + 16'(k));
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        check("midrst_txd",  {31'd0, txd},  32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_full", {31'd0, full}, 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            cycle(1'b0, 16'h0000);
            if (txd !== 1'b1) lows++;
        end
        check("midrst_silent", lows, 32'd0);

        // 0x0000 then 0xFFFF: 80 low cycles total, contiguous words.
        do_reset();
        zeros = 0; first_low = -1; last_low = -1; full_seen = 0;
        for (int k = 1; k < 190; k++) begin
            cycle(k <= 2, (k == 1) ? 16'h0000 : 16'hFFFF);
            if (txd === 1'b0) begin
                zeros++;
                if (first_low < 0) first_low = k;
                last_low = k;
            end
            if (full === 1'b1) full_seen++;
        end
        check("zf_zeros", zeros, 32'd80);
        check("zf_span",  last_low - first_low, 32'd123);
        check("zf_full",  full_seen, 32'd0);

        // Random traffic at several strobe densities.
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            case (ph % 4)
                0: p = 2;
                1: p = 30;
                2: p = 80;
                default: p = 6;
            endcase
            for (int k = 0; k < 500; k++)
                cycle($urandom_range(0, 99) < p, 16'($urandom));
            if (ph == 3) do_reset();
        end
        for (int k = 0; k < (DEPTH + 1) * 20 * CPB + 10; k++) cycle(1'b0, 16'h0000);
        check("rand_drained", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
